control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired Moore control unit that sits directly upstream of the datapath and drives every control strobe the datapath consumes.
- Each instruction runs as fetch, then decode, then execute: T0..T2 for fetch, decode in T3, execute in T3..T6.
- It replaces hand-sequenced stimulus for ALU register/immediate, MUL/DIV, NEG/NOT, NOP and HALT instructions.
- Register selection uses select-and-encode strobes (Gra/Grb/Grc with Rin/Rout). Immediates use Cout.

Parameters:
- HALT_ON_ILLEGAL, 0: 1 = an undefined opcode enters HALT; 0 = an undefined opcode executes as NOP.

Ports:
- Clock  in  1  rising-edge clock
- Clear  in  1  asynchronous reset, active-low
- IR  in  32  instruction register contents from the datapath. Fields: op=IR[31:27], Ra=[26:23], Rb=[22:19], Rc=[18:15].
- Stop  in  1  halt request; sampled only at instruction boundary
- PCout, MDRout, Zhighout, Zlowout, HIout, LOout  out  1 each  bus drive strobes
- PCin, MARin, MDRin, IRin, Zin, Yin, HIin, LOin  out  1 each  register load strobes
- IncPC, Read  out  1 each  PC increment, memory read
- Gra, Grb, Grc, Rin, Rout, Cout  out  1 each  select-and-encode controls
- alu_op  out  13  one-hot. Bit order 0..12: ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT.
- Run  out  1  high except in HALT

Behaviour:
- State register, 4 bits. States: RST, T0, T1, T2, T3, T4, T5, T6, HALT. Advances on posedge Clock.
- Outputs are a pure decode of state and latched opcode. There are no glitch paths from IR except in T3..T6.
- While Clear=0: state=RST asynchronously, all strobes 0, alu_op=0, Run=1.
- First posedge after Clear rises: RST->T0.
- Clear asserted mid-instruction aborts the instruction immediately. No partial register write occurs after reset.
- Fetch, one cycle each:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Opcode map:
  - add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011
  - addi 01100, andi 01101, ori 01110
  - mul 01111, div 10000, neg 10001, not 10010
  - nop 11010, halt 11011
- Opcode is captured on entry to T3 (IR is valid after T2's IRin edge) and held until T0.
- Three-register ALU (add..shl):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, alu_op bit, Zin.
  - T5: Zlowout, Gra, Rin, then go to T0. Total 6 cycles.
- Immediate (addi/andi/ori): as three-register ALU, except T4 uses Cout in place of Grc/Rout. alu_op is ADD/AND/OR respectively.
- neg/not:
  - T3: Grb, Rout, alu_op bit, Zin.
  - T4: Zlowout, Gra, Rin, then go to T0. Total 5 cycles.
- mul/div:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, alu_op bit, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin, then go to T0. Total 7 cycles.
- nop: T3 asserts nothing, then go to T0.
- halt: T3 -> HALT.
- Illegal opcode: nop path if HALT_ON_ILLEGAL=0; HALT path otherwise.
- HALT: all strobes 0, Run=0. HALT is left only by Clear.
- Stop: checked on the transition into T0, i.e. at the last execute state. If Stop=1, go to HALT instead of T0. A Stop pulse during fetch or mid-execute is ignored unless it is still high at the boundary.
- At most one alu_op bit is high, and only in the cycle where Zin=1 during execute. Zin is also high in T0, with alu_op=0; the datapath increments via IncPC.
- Never asserted together: Rin with Rout; MARin with IRin; any two bus drivers (PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Rout, Cout).

Test Plan:
- Reset: Clear=0 mid-T4 of add -> all strobes 0 within the same time step, state=RST. Clear=1 -> T0 strobes (PCout, MARin, IncPC, Zin) on the next edge.
- add R1,R2,R3 (IR=0x18918000) -> exact sequence T0,T1,T2, then T3 Grb+Rout+Yin, T4 Grc+Rout+alu_op=0x0001+Zin, T5 Zlowout+Gra+Rin, then T0.
- mul R3,R1 (IR=0x79880000) -> T4 alu_op=0x0200; T5 Zlowout+LOin; T6 Zhighout+HIin; 7 cycles total, then T0.
- addi (IR=0x60000000 with fields set) -> T4 Cout=1, Grc=0, alu_op=0x0001.
- halt (IR=0xD8000000) -> HALT after T3, Run=0, state held for 20 cycles.
- Stop=1 during T1 then 0 -> ignored. Stop=1 at last execute state -> HALT.
- Illegal opcode (IR=0xF8000000): HALT_ON_ILLEGAL=0 -> nop path, back to T0 after T3. HALT_ON_ILLEGAL=1 -> HALT.
- Checker every cycle: mutual-exclusion rules hold and alu_op is one-hot or zero.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0..T2, decode/execute T3..T6.
// Drives every datapath strobe from state plus the captured opcode.
module control_sequencer #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        MDRout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIout,
    output logic        LOout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Zin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        Cout,
    output logic [12:0] alu_op,
    output logic        Run
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t      state;
    state_t      boundary;
    logic [4:0]  op_q;
    logic [4:0]  op;
    logic        is_alu3, is_imm, is_md, is_un, is_halt, is_ill, to_halt;
    logic [12:0] aop;
    logic        unused_fields;

    // Register fields are consumed by the datapath's select-and-encode logic.
    assign unused_fields = ^IR[26:0];

    // IR is loaded on the same edge that enters T3, so T3 decodes it live.
    assign op = (state == S_T3) ? IR[31:27] : op_q;

    always_comb begin
        is_alu3 = (op >= 5'd3) && (op <= 5'd11);
        is_imm  = (op >= 5'd12) && (op <= 5'd14);
        is_md   = (op == 5'd15) || (op == 5'd16);
        is_un   = (op == 5'd17) || (op == 5'd18);
        is_halt = (op == 5'd27);
        is_ill  = !(is_alu3 || is_imm || is_md || is_un || is_halt
                    || (op == 5'd26));
        to_halt = is_halt || (is_ill && HALT_ON_ILLEGAL);
        boundary = Stop ? S_HALT : S_T0;
    end

    always_comb begin
        case (op)
            5'd3, 5'd12: aop = 13'h0001;
            5'd4:        aop = 13'h0002;
            5'd5, 5'd13: aop = 13'h0004;
            5'd6, 5'd14: aop = 13'h0008;
            5'd7:        aop = 13'h0080;
            5'd8:        aop = 13'h0100;
            5'd9:        aop = 13'h0010;
            5'd10:       aop = 13'h0020;
            5'd11:       aop = 13'h0040;
            5'd15:       aop = 13'h0200;
            5'd16:       aop = 13'h0400;
            5'd17:       aop = 13'h0800;
            5'd18:       aop = 13'h1000;
            default:     aop = 13'h0000;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state <= S_RST;
            op_q  <= '0;
        end else begin
            case (state)
                S_RST: state <= S_T0;
                S_T0:  state <= S_T1;
                S_T1:  state <= S_T2;
                S_T2:  state <= S_T3;
                S_T3: begin
                    op_q <= IR[31:27];
                    if (to_halt)
                        state <= S_HALT;
                    else if (is_alu3 || is_imm || is_md || is_un)
                        state <= S_T4;
                    else
                        state <= boundary;
                end
                S_T4:   state <= is_un ? boundary : S_T5;
                S_T5:   state <= is_md ? S_T6 : boundary;
                S_T6:   state <= boundary;
                S_HALT: state <= S_HALT;
                default: state <= S_RST;
            endcase
        end
    end

    always_comb begin
        {PCout, MDRout, Zhighout, Zlowout, HIout, LOout} = '0;
        {PCin, MARin, MDRin, IRin, Zin, Yin, HIin, LOin} = '0;
        {IncPC, Read, Gra, Grb, Grc, Rin, Rout, Cout}    = '0;
        alu_op = '0;
        Run    = (state != S_HALT);
        case (state)
            S_T0: {PCout, MARin, IncPC, Zin} = 4'b1111;
            S_T1: {Zlowout, PCin, Read, MDRin} = 4'b1111;
            S_T2: {MDRout, IRin} = 2'b11;
            S_T3: begin
                if (is_alu3 || is_imm) begin
                    {Grb, Rout, Yin} = 3'b111;
                end else if (is_md) begin
                    {Gra, Rout, Yin} = 3'b111;
                end else if (is_un) begin
                    {Grb, Rout, Zin} = 3'b111;
                    alu_op = aop;
                end
            end
            S_T4: begin
                if (is_alu3) begin
                    {Grc, Rout, Zin} = 3'b111;
                    alu_op = aop;
                end else if (is_imm) begin
                    {Cout, Zin} = 2'b11;
                    alu_op = aop;
                end else if (is_md) begin
                    {Grb, Rout, Zin} = 3'b111;
                    alu_op = aop;
                end else if (is_un) begin
                    {Zlowout, Gra, Rin} = 3'b111;
                end
            end
            S_T5: begin
                if (is_alu3 || is_imm)
                    {Zlowout, Gra, Rin} = 3'b111;
                else if (is_md)
                    {Zlowout, LOin} = 2'b11;
            end
            S_T6: if (is_md) {Zhighout, HIin} = 2'b11;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: both HALT_ON_ILLEGAL settings side by side
// against an instruction-level model of the control-word sequences.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic        Stop  = 1'b0;
    logic [31:0] IR    = '0;
    wire  [35:0] o0;
    wire  [35:0] o1;
    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    localparam logic [35:0] PCOUT  = 36'd1 << 35;
    localparam logic [35:0] MDROUT = 36'd1 << 34;
    localparam logic [35:0] ZHIGH  = 36'd1 << 33;
    localparam logic [35:0] ZLOW   = 36'd1 << 32;
    localparam logic [35:0] HIOUT  = 36'd1 << 31;
    localparam logic [35:0] LOOUT  = 36'd1 << 30;
    localparam logic [35:0] PCIN   = 36'd1 << 29;
    localparam logic [35:0] MARIN  = 36'd1 << 28;
    localparam logic [35:0] MDRIN  = 36'd1 << 27;
    localparam logic [35:0] IRIN   = 36'd1 << 26;
    localparam logic [35:0] ZIN    = 36'd1 << 25;
    localparam logic [35:0] YIN    = 36'd1 << 24;
    localparam logic [35:0] HIIN   = 36'd1 << 23;
    localparam logic [35:0] LOIN   = 36'd1 << 22;
    localparam logic [35:0] INCPC  = 36'd1 << 21;
    localparam logic [35:0] READ   = 36'd1 << 20;
    localparam logic [35:0] GRA    = 36'd1 << 19;
    localparam logic [35:0] GRB    = 36'd1 << 18;
    localparam logic [35:0] GRC    = 36'd1 << 17;
    localparam logic [35:0] RIN    = 36'd1 << 16;
    localparam logic [35:0] ROUT   = 36'd1 << 15;
    localparam logic [35:0] COUT   = 36'd1 << 14;
    localparam logic [35:0] RUN    = 36'd1 << 13;
    localparam logic [35:0] BUS    = PCOUT | MDROUT | ZHIGH | ZLOW
                                   | HIOUT | LOOUT | ROUT | COUT;
    localparam logic [35:0] F0 = PCOUT | MARIN | INCPC | ZIN | RUN;
    localparam logic [35:0] F1 = ZLOW | PCIN | READ | MDRIN | RUN;
    localparam logic [35:0] F2 = MDROUT | IRIN | RUN;

    control_sequencer #(.HALT_ON_ILLEGAL(1'b0)) u0 (
        .Clock(Clock), .Clear(Clear), .IR(IR), .Stop(Stop),
        .PCout(o0[35]), .MDRout(o0[34]), .Zhighout(o0[33]),
        .Zlowout(o0[32]), .HIout(o0[31]), .LOout(o0[30]),
        .PCin(o0[29]), .MARin(o0[28]), .MDRin(o0[27]), .IRin(o0[26]),
        .Zin(o0[25]), .Yin(o0[24]), .HIin(o0[23]), .LOin(o0[22]),
        .IncPC(o0[21]), .Read(o0[20]), .Gra(o0[19]), .Grb(o0[18]),
        .Grc(o0[17]), .Rin(o0[16]), .Rout(o0[15]), .Cout(o0[14]),
        .alu_op(o0[12:0]), .Run(o0[13])
    );

    control_sequencer #(.HALT_ON_ILLEGAL(1'b1)) u1 (
        .Clock(Clock), .Clear(Clear), .IR(IR), .Stop(Stop),
        .PCout(o1[35]), .MDRout(o1[34]), .Zhighout(o1[33]),
        .Zlowout(o1[32]), .HIout(o1[31]), .LOout(o1[30]),
        .PCin(o1[29]), .MARin(o1[28]), .MDRin(o1[27]), .IRin(o1[26]),
        .Zin(o1[25]), .Yin(o1[24]), .HIin(o1[23]), .LOin(o1[22]),
        .IncPC(o1[21]), .Read(o1[20]), .Gra(o1[19]), .Grb(o1[18]),
        .Grc(o1[17]), .Rin(o1[16]), .Rout(o1[15]), .Cout(o1[14]),
        .alu_op(o1[12:0]), .Run(o1[13])
    );

    // Execute-phase control words of one instruction, in order.
    typedef struct packed {
        logic [6:0][35:0] w;
        logic [2:0]       len;
        logic             halt_after;
    } prog_t;

    function automatic logic [35:0] aop(input logic [4:0] op);
        case (op)
            5'd3, 5'd12: return 36'd1 << 0;
            5'd4:        return 36'd1 << 1;
            5'd5, 5'd13: return 36'd1 << 2;
            5'd6, 5'd14: return 36'd1 << 3;
            5'd9:        return 36'd1 << 4;
            5'd10:       return 36'd1 << 5;
            5'd11:       return 36'd1 << 6;
            5'd7:        return 36'd1 << 7;
            5'd8:        return 36'd1 << 8;
            5'd15:       return 36'd1 << 9;
            5'd16:       return 36'd1 << 10;
            5'd17:       return 36'd1 << 11;
            5'd18:       return 36'd1 << 12;
            default:     return '0;
        endcase
    endfunction

    function automatic prog_t decode_prog(input logic [4:0] op, input bit hi);
        prog_t p;
        logic [35:0] a;
        p = '0;
        a = aop(op);
        if (op >= 3 && op <= 11) begin
            p.w[0] = GRB | ROUT | YIN;
            p.w[1] = GRC | ROUT | ZIN | a;
            p.w[2] = ZLOW | GRA | RIN;
            p.len = 3;
        end else if (op >= 12 && op <= 14) begin
            p.w[0] = GRB | ROUT | YIN;
            p.w[1] = COUT | ZIN | a;
            p.w[2] = ZLOW | GRA | RIN;
            p.len = 3;
        end else if (op == 15 || op == 16) begin
            p.w[0] = GRA | ROUT | YIN;
            p.w[1] = GRB | ROUT | ZIN | a;
            p.w[2] = ZLOW | LOIN;
            p.w[3] = ZHIGH | HIIN;
            p.len = 4;
        end else if (op == 17 || op == 18) begin
            p.w[0] = GRB | ROUT | ZIN | a;
            p.w[1] = ZLOW | GRA | RIN;
            p.len = 2;
        end else begin
            p.len = 1;
            p.halt_after = (op == 27) || (op != 26 && hi);
        end
        for (int i = 0; i < 7; i++)
            if (i < int'(p.len)) p.w[i] = p.w[i] | RUN;
        return p;
    endfunction

    bit         m_rst [2];
    bit         m_halt[2];
    int         m_pos [2];
    logic [4:0] m_op  [2];

    function automatic logic [35:0] exp_word(input int k);
        prog_t p;
        if (m_rst[k]) return RUN;
        if (m_halt[k]) return '0;
        case (m_pos[k])
            0: return F0;
            1: return F1;
            2: return F2;
            3: begin
                p = decode_prog(IR[31:27], k == 1);
                return p.w[0];
            end
            default: begin
                p = decode_prog(m_op[k], k == 1);
                return p.w[m_pos[k] - 3];
            end
        endcase
    endfunction

    task automatic model_step(input int k);
        prog_t p;
        if (m_rst[k]) begin
            m_rst[k] = 0;
            m_pos[k] = 0;
        end else if (!m_halt[k]) begin
            if (m_pos[k] < 3) begin
                m_pos[k]++;
            end else begin
                if (m_pos[k] == 3) m_op[k] = IR[31:27];
                p = decode_prog(m_op[k], k == 1);
                if (m_pos[k] == 3 && p.halt_after) m_halt[k] = 1;
                else if (m_pos[k] - 3 == int'(p.len) - 1) begin
                    if (Stop) m_halt[k] = 1;
                    else m_pos[k] = 0;
                end else m_pos[k]++;
            end
        end
    endtask

    task automatic check(input string name, input logic [35:0] got,
                         input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
        end
    endtask

    task automatic rules(input string name, input logic [35:0] o);
        int ok;
        ok = 1;
        if ((o & (RIN | ROUT)) == (RIN | ROUT)) ok = 0;
        if ((o & (MARIN | IRIN)) == (MARIN | IRIN)) ok = 0;
        if ($countones(o & BUS) > 1) ok = 0;
        if ($countones(o[12:0]) > 1) ok = 0;
        if (o[12:0] != 0 && (o & ZIN) == 0) ok = 0;
        check_int(name, ok, 1);
    endtask

    task automatic tick();
        @(posedge Clock);
        model_step(0);
        model_step(1);
        #1;
        check("word0", o0, exp_word(0));
        check("word1", o1, exp_word(1));
        rules("rules0", o0);
        rules("rules1", o1);
    endtask

    task automatic do_reset();
        Clear = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            m_rst[k] = 1;
            m_halt[k] = 0;
            m_pos[k] = 0;
        end
        check("clr0", o0, RUN);
        check("clr1", o1, RUN);
        @(negedge Clock);
        Clear = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        int r;
        logic [4:0] op;
        r = $urandom_range(0, 19);
        if (r < 16) op = 5'(r + 3);
        else if (r == 16) op = 5'd26;
        else if (r == 17) op = 5'd27;
        else op = 5'($urandom_range(0, 31));
        return {op, 27'($urandom)};
    endfunction

    typedef struct {
        logic [31:0] ir;
        int          len;
        bit          run0;
        bit          run1;
    } vec_t;

    localparam logic [31:0] ADD_IR  = 32'h18918000;
    localparam logic [31:0] MUL_IR  = 32'h79880000;
    localparam logic [31:0] ADDI_IR = 32'h60918000;
    localparam logic [31:0] HALT_IR = 32'hD8000000;

    initial begin
        vec_t tbl[8];
        int n;
        tbl[0] = '{ADD_IR, 6, 1, 1};
        tbl[1] = '{MUL_IR, 7, 1, 1};
        tbl[2] = '{ADDI_IR, 6, 1, 1};
        tbl[3] = '{32'h88900000, 5, 1, 1};
        tbl[4] = '{32'h90900000, 5, 1, 1};
        tbl[5] = '{32'hD0000000, 4, 1, 1};
        tbl[6] = '{HALT_IR, 4, 0, 0};
        tbl[7] = '{32'hF8000000, 4, 1, 0};

        for (int i = 0; i < 8; i++) begin
            do_reset();
            tick();
            IR = tbl[i].ir;
            n = 0;
            do begin
                tick();
                n++;
            end while ((o0 & PCOUT) == 0 && o0[13] && n < 20);
            check_int("len", n, tbl[i].len);
            check_int("run0", int'(o0[13]), int'(tbl[i].run0));
            check_int("run1", int'(o1[13]), int'(tbl[i].run1));
        end

        // Clear in the middle of add's T4, then restart.
        do_reset();
        tick();
        IR = ADD_IR;
        repeat (4) tick();
        check("add_t4", o0, GRC | ROUT | ZIN | RUN | 36'h0001);
        do_reset();
        tick();
        check("t0_after_clr", o0, F0);

        IR = MUL_IR;
        repeat (4) tick();
        check("mul_t4", o0, GRB | ROUT | ZIN | RUN | 36'h0200);
        tick();
        check("mul_t5", o0, ZLOW | LOIN | RUN);
        tick();
        check("mul_t6", o0, ZHIGH | HIIN | RUN);
        tick();
        check("mul_t0", o0, F0);

        IR = ADDI_IR;
        repeat (4) tick();
        check("addi_t4", o0, COUT | ZIN | RUN | 36'h0001);
        repeat (2) tick();

        IR = HALT_IR;
        repeat (4) tick();
        repeat (20) begin
            tick();
            check_int("halt_run", int'(o0[13]), 0);
        end

        // Stop pulse during fetch is ignored; Stop at T5 halts.
        do_reset();
        tick();
        IR = ADD_IR;
        tick();
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        repeat (4) tick();
        check("stop_ignored", o0, F0);
        repeat (5) tick();
        Stop = 1'b1;
        tick();
        check_int("stop_halt", int'(o0[13]), 0);
        Stop = 1'b0;

        do_reset();
        tick();
        for (int c = 0; c < 600; c++) begin
            if (m_halt[0] || m_halt[1] || $urandom_range(0, 59) == 0) begin
                Stop = 1'b0;
                do_reset();
            end else begin
                if (m_pos[0] == 0) IR = rand_instr();
                else if (m_pos[0] >= 4) IR = $urandom;
                Stop = ($urandom_range(0, 7) == 0);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
